if_id_queue: RTL and testbench

- Parametrised instruction buffer between IF and ID; successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched (pc, inst) pairs so fetch keeps running while ID stalls.
- Flushes on redirect (branch/jump) and presents a zero bubble to ID when empty.

---
 rtl/if_id_queue.sv | 89 ++++++++
 tb/tb_if_id_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry circular instruction buffer between IF and ID.
// Flushes on redirect and presents a zero bubble to ID when empty.
`default_nettype none

module if_id_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         flush_in,
  input  logic                         stall_in,
  input  logic                         if_valid_in,
  input  logic [ADDR_WIDTH-1:0]        pc_in,
  input  logic [INST_WIDTH-1:0]        inst_in,
  output logic                         if_ready_out,
  output logic                         id_valid_out,
  output logic [ADDR_WIDTH-1:0]        pc_out,
  output logic [INST_WIDTH-1:0]        inst_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push;
  logic pop;

  assign if_ready_out = (count_q != FULL);
  assign id_valid_out = (count_q != '0);
  assign push = if_valid_in & if_ready_out & ~flush_in;
  assign pop  = id_valid_out & ~stall_in & ~flush_in;

  // Empty queue drives a nop bubble rather than stale entry contents.
  assign pc_out    = id_valid_out ? pc_mem_q[rd_ptr_q]   : '0;
  assign inst_out  = id_valid_out ? inst_mem_q[rd_ptr_q] : '0;
  assign count_out = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_in) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= pc_in;
      inst_mem_q[wr_ptr_q] <= inst_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed scenarios plus random traffic checked every cycle
// against a queue-based model of the instruction buffer.
`default_nettype none

module tb_if_id_queue;

  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          flush_in = 1'b0;
  logic          stall_in = 1'b0;
  logic          if_valid_in = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic [IW-1:0] inst_in = '0;
  logic          if_ready_out;
  logic          id_valid_out;
  logic [AW-1:0] pc_out;
  logic [IW-1:0] inst_out;
  logic [CW-1:0] count_out;

  if_id_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .stall_in(stall_in),
    .if_valid_in(if_valid_in), .pc_in(pc_in), .inst_in(inst_in),
    .if_ready_out(if_ready_out), .id_valid_out(id_valid_out),
    .pc_out(pc_out), .inst_out(inst_out), .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of (pc, inst) pairs.
  logic [AW-1:0] m_pc[$];
  logic [IW-1:0] m_inst[$];
  bit started = 1'b0;

  always @(posedge clk_in) begin
    bit was_full, do_pop, do_push;
    if (rst_in) begin
      m_pc.delete(); m_inst.delete();
      started = 1'b1;
    end else if (flush_in) begin
      m_pc.delete(); m_inst.delete();
    end else begin
      was_full = (m_pc.size() == DEPTH);
      do_pop   = (m_pc.size() != 0) && !stall_in;
      do_push  = if_valid_in && !was_full;
      if (do_pop) begin
        void'(m_pc.pop_front()); void'(m_inst.pop_front());
      end
      if (do_push) begin
        m_pc.push_back(pc_in); m_inst.push_back(inst_in);
      end
    end
  end

  always @(negedge clk_in) begin
    if (started) begin
      check("count",    32'(count_out),    32'(m_pc.size()));
      check("if_ready", 32'(if_ready_out), 32'(m_pc.size() != DEPTH));
      check("id_valid", 32'(id_valid_out), 32'(m_pc.size() != 0));
      check("pc",   pc_out,   (m_pc.size()   != 0) ? m_pc[0]   : '0);
      check("inst", inst_out, (m_inst.size() != 0) ? m_inst[0] : '0);
    end
  end

  task automatic step(input bit rst, input bit flush, input bit stall,
                      input bit vld, input logic [AW-1:0] pc, input logic [IW-1:0] inst);
    rst_in = rst; flush_in = flush; stall_in = stall;
    if_valid_in = vld; pc_in = pc; inst_in = inst;
    @(posedge clk_in);
    #1;
  endtask

  logic [IW-1:0] fill_inst [3];

  initial begin
    fill_inst[0] = 32'h0000_0013;
    fill_inst[1] = 32'h0010_0093;
    fill_inst[2] = 32'h0020_0113;

    // Reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("rst_ready", 32'(if_ready_out), 32'd1);
    check("rst_valid", 32'(id_valid_out), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_pc", pc_out, 32'd0);

    // Fill without stall: each pair visible one cycle after its push
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 32'(4*i), fill_inst[i]);
      check("fill_pc", pc_out, 32'(4*i));
      check("fill_inst", inst_out, fill_inst[i]);
      check("fill_cnt_le1", 32'(count_out <= 1), 32'd1);
    end
    step(0, 0, 0, 0, 0, 0);
    check("fill_drained", 32'(id_valid_out), 32'd0);

    // Stall to full: fifth push refused, head held
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 32'(32'h10 + 4*i), 32'(32'hA0 + i));
    check("full_count", 32'(count_out), 32'd4);
    check("full_ready", 32'(if_ready_out), 32'd0);
    check("full_head", pc_out, 32'h10);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", pc_out, 32'(32'h10 + 4*i));
      step(0, 0, 0, 0, 0, 0);
    end
    check("drain_empty", 32'(count_out), 32'd0);

    // Wrap-around with alternating stall
    for (int i = 0; i < 12; i++) step(0, 0, i[0], 1, 32'(32'h100 + 4*i), 32'(i));
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

    // Simultaneous push/pop at count = 2
    step(0, 0, 1, 1, 32'h50, 32'h5);
    step(0, 0, 1, 1, 32'h54, 32'h6);
    check("pp_cnt_before", 32'(count_out), 32'd2);
    step(0, 0, 0, 1, 32'h58, 32'h7);
    check("pp_cnt_after", 32'(count_out), 32'd2);
    check("pp_head", pc_out, 32'h54);

    // Flush with stall and concurrent push
    step(0, 0, 1, 1, 32'h5C, 32'h8);
    check("fl_cnt3", 32'(count_out), 32'd3);
    step(0, 1, 1, 1, 32'h40, 32'h9);
    check("fl_count", 32'(count_out), 32'd0);
    check("fl_valid", 32'(id_valid_out), 32'd0);
    check("fl_pc", pc_out, 32'd0);
    check("fl_inst", inst_out, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("fl_no40", 32'(id_valid_out), 32'd0);

    // Reset mid-operation at full with push
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'(32'h60 + 4*i), 32'(i));
    check("mr_full", 32'(count_out), 32'd4);
    step(1, 0, 1, 1, 32'h70, 32'h1);
    check("mr_count", 32'(count_out), 32'd0);
    check("mr_ready", 32'(if_ready_out), 32'd1);
    check("mr_valid", 32'(id_valid_out), 32'd0);
    check("mr_pc", pc_out, 32'd0);
    step(0, 0, 0, 1, 32'h80, 32'hDEAD);
    check("mr_push_pc", pc_out, 32'h80);
    check("mr_push_valid", 32'(id_valid_out), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 60),
           $urandom, $urandom);
    end
    step(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
